// File: rtl/host_cmd_initiator.sv
// Host-side initiator: shifts an activation key to the memory access controller,
// issues one read/write command and follows the controller's Busy handshake.
module host_cmd_initiator #(
  parameter int                    KEY_WIDTH = 4,
  parameter logic [KEY_WIDTH-1:0]  KEY_VALUE = 4'b1011,
  parameter int                    TIMEOUT   = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       ReqRW,
  input  logic       Active,
  input  logic       Busy,
  output logic       InputKey,
  output logic       ValidCmd,
  output logic       RW,
  output logic       HostBusy,
  output logic       Done,
  output logic       Error,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int IW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(KEY_WIDTH - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_KEY     = 3'd1,
    WAIT_ACTIVE  = 3'd2,
    CMD          = 3'd3,
    WAIT_BUSY_HI = 3'd4,
    WAIT_BUSY_LO = 3'd5,
    FINISH       = 3'd6,
    ABORT        = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic          input_key_q, input_key_d;
  logic          valid_cmd_q, valid_cmd_d;
  logic          host_busy_q, host_busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          timed_out;

  assign timed_out = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          rw_d    = ReqRW;
          idx_d   = '0;
          state_d = Active ? CMD : SEND_KEY;
        end
      end
      SEND_KEY: begin
        if (idx_q == LAST_IDX) state_d = WAIT_ACTIVE;
        else                   idx_d   = idx_q + 1'b1;
      end
      WAIT_ACTIVE: begin
        if (Active)         state_d = CMD;
        else if (timed_out) state_d = ABORT;
      end
      CMD: state_d = WAIT_BUSY_HI;
      WAIT_BUSY_HI: begin
        if (Busy)           state_d = WAIT_BUSY_LO;
        else if (timed_out) state_d = ABORT;
      end
      WAIT_BUSY_LO: begin
        if (!Busy)          state_d = FINISH;
        else if (timed_out) state_d = ABORT;
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any state change restarts the wait budget; otherwise count up and stick at max.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == '1)    cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;

    // Key bit, busy and done track the state being entered so they line up with it.
    input_key_d = (state_d == SEND_KEY) ? KEY_VALUE[LAST_IDX - idx_d] : 1'b0;
    host_busy_d = (state_d != IDLE);
    done_d      = (state_d == FINISH) || (state_d == ABORT);
    error_d     = (state_d == ABORT);
    // The strobe follows the CMD cycle, giving two cycles from an already-active Start.
    valid_cmd_d = (state_q == CMD);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      input_key_q <= 1'b0;
      valid_cmd_q <= 1'b0;
      host_busy_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      input_key_q <= input_key_d;
      valid_cmd_q <= valid_cmd_d;
      host_busy_q <= host_busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign InputKey  = input_key_q;
  assign ValidCmd  = valid_cmd_q;
  assign RW        = rw_q;
  assign HostBusy  = host_busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_host_cmd_initiator.sv
// Directed bench for host_cmd_initiator: inputs change and outputs are checked
// on the falling edge of Clk.
module tb_host_cmd_initiator;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WACT = 3'd2;
  localparam logic [2:0] S_WBLO = 3'd5;

  logic       Clk, Reset, Start, ReqRW, Active, Busy;
  logic       InputKey, ValidCmd, RW, HostBusy, Done, Error;
  logic [2:0] dbg_state;

  int total  = 0;
  int passed = 0;
  int vc_cnt = 0;
  int d_cnt  = 0;

  host_cmd_initiator dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ReqRW(ReqRW),
    .Active(Active), .Busy(Busy), .InputKey(InputKey), .ValidCmd(ValidCmd),
    .RW(RW), .HostBusy(HostBusy), .Done(Done), .Error(Error),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (ValidCmd) vc_cnt++;
    if (Done)     d_cnt++;
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Packs {InputKey,ValidCmd,RW,HostBusy,Done,Error} for whole-output checks.
  function automatic logic [5:0] outs();
    return {InputKey, ValidCmd, RW, HostBusy, Done, Error};
  endfunction

  initial begin
    Reset = 1'b0; Start = 1'b0; ReqRW = 1'b0; Active = 1'b0; Busy = 1'b0;
    tick(); tick();
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    Reset = 1'b1;
    tick();
    chk("idle_hostbusy", 32'(HostBusy), 32'h0);

    // Key path, read request, Active raised late, Busy high for 3 cycles
    ReqRW = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0; ReqRW = 1'b0;
    chk("t2_key0", 32'(InputKey), 32'h1);
    chk("t2_hostbusy", 32'(HostBusy), 32'h1);
    tick(); chk("t2_key1", 32'(InputKey), 32'h0);
    tick(); chk("t2_key2", 32'(InputKey), 32'h1);
    tick(); chk("t2_key3", 32'(InputKey), 32'h1);
    tick();
    chk("t2_key_end", 32'(InputKey), 32'h0);
    chk("t2_wait_active", 32'(dbg_state), 32'(S_WACT));
    tick();
    Active = 1'b1;
    tick(); chk("t2_no_early_cmd", 32'(ValidCmd), 32'h0);
    tick();
    chk("t2_validcmd", 32'(ValidCmd), 32'h1);
    chk("t2_rw", 32'(RW), 32'h1);
    Busy = 1'b1;
    tick(); chk("t2_cmd_one_cycle", 32'(ValidCmd), 32'h0);
    tick(); tick();
    Busy = 1'b0;
    tick(); chk("t2_done", 32'({Done, Error}), 32'h2);
    tick(); chk("t2_back_idle", 32'({Done, HostBusy}), 32'h0);

    // Already-active path, write request
    ReqRW = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t3_cycle1", 32'({InputKey, ValidCmd, HostBusy}), 32'h1);
    tick();
    chk("t3_validcmd", 32'({InputKey, ValidCmd, RW, HostBusy}), 32'h5);
    Busy = 1'b1;
    tick(); tick();
    Busy = 1'b0;
    tick(); chk("t3_done", 32'({Done, Error, HostBusy}), 32'h5);
    tick();

    // Active never comes: abort after 16 cycles in WAIT_ACTIVE
    Active = 1'b0; ReqRW = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t4_wait_%0d", i), 32'({ValidCmd, Done, dbg_state}), 32'(S_WACT));
    end
    tick();
    chk("t4_abort", 32'({InputKey, ValidCmd, Done, Error}), 32'h3);
    tick(); chk("t4_idle", 32'({Done, HostBusy}), 32'h0);

    // Busy stuck high: abort 16 cycles after entering WAIT_BUSY_LO
    Active = 1'b1; ReqRW = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); chk("t5_validcmd", 32'({ValidCmd, RW}), 32'h3);
    Busy = 1'b1;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("t5_wait_%0d", i), 32'({Done, dbg_state}), 32'(S_WBLO));
    end
    tick(); chk("t5_abort", 32'({Done, Error}), 32'h3);
    Busy = 1'b0;
    tick(); chk("t5_idle", 32'(HostBusy), 32'h0);
    ReqRW = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); chk("t5_retry_cmd", 32'({ValidCmd, RW}), 32'h2);
    Busy = 1'b1;
    tick();
    Busy = 1'b0;
    tick(); chk("t5_retry_done", 32'({Done, Error}), 32'h2);
    tick();

    // Extra Start pulses during SEND_KEY and WAIT_BUSY_LO are dropped
    Active = 1'b0; vc_cnt = 0; d_cnt = 0;
    ReqRW = 1'b0; Start = 1'b1;
    tick();
    ReqRW = 1'b1;
    tick();
    Start = 1'b0;
    chk("t6_key1_unaffected", 32'(InputKey), 32'h0);
    tick(); tick(); tick();
    Active = 1'b1;
    tick(); tick();
    chk("t6_validcmd", 32'({ValidCmd, RW}), 32'h2);
    Busy = 1'b1;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0; Busy = 1'b0;
    tick(); tick(); tick();
    chk("t6_not_queued", 32'(HostBusy), 32'h0);
    chk("t6_one_validcmd", 32'(vc_cnt), 32'd1);
    chk("t6_one_done", 32'(d_cnt), 32'd1);
    chk("t6_rw_held", 32'(RW), 32'h0);

    // Reset in the middle of SEND_KEY, then restart from key bit 0
    Active = 1'b0; ReqRW = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    chk("t1_reset_outs", 32'(outs()), 32'h0);
    chk("t1_reset_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    chk("t1_reset_outs2", 32'(outs()), 32'h0);
    Reset = 1'b1;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t1_restart_key0", 32'({InputKey, HostBusy}), 32'h3);
    tick(); chk("t1_restart_key1", 32'(InputKey), 32'h0);
    tick(); chk("t1_restart_key2", 32'(InputKey), 32'h1);
    tick(); chk("t1_restart_key3", 32'(InputKey), 32'h1);
    Reset = 1'b0;
    tick();
    chk("t1_final_reset", 32'(outs()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
